// File: rtl/fpadd_issue_wb.sv
// Issue/writeback wrapper for the pipelined FP adder: credit-gated issue, a tag pipe
// matched to the adder latency, a show-ahead result FIFO and sticky exception flags.
module fpadd_issue_wb #(
  parameter int DWIDTH  = 32,
  parameter int TWIDTH  = 5,
  parameter int LATENCY = 5,
  parameter int DEPTH   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DWIDTH-1:0] req_a,
  input  logic [DWIDTH-1:0] req_b,
  input  logic [TWIDTH-1:0] req_tag,
  output logic              fpu_valid,
  output logic [DWIDTH-1:0] fpu_a,
  output logic [DWIDTH-1:0] fpu_b,
  input  logic [DWIDTH-1:0] fpu_sum,
  input  logic [2:0]        fpu_fex,
  input  logic              fpu_done,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DWIDTH-1:0] wb_sum,
  output logic [2:0]        wb_fex,
  output logic [TWIDTH-1:0] wb_tag,
  output logic [2:0]        fflags,
  input  logic              fflags_clr,
  output logic              seq_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [DWIDTH-1:0] sum;
    logic [2:0]        fex;
    logic [TWIDTH-1:0] tag;
  } res_t;

  logic                           r_fpu_valid;
  logic [DWIDTH-1:0]              r_fpu_a, r_fpu_b;
  logic [TWIDTH-1:0]              r_tag;
  logic [LATENCY-1:0]             r_vld_pipe;
  logic [LATENCY-1:0][TWIDTH-1:0] r_tag_pipe;
  logic [CW-1:0]                  r_inflight, r_count;
  logic [AW-1:0]                  r_wptr, r_rptr;
  res_t                           r_mem [DEPTH];
  logic [2:0]                     r_fflags;
  logic                           r_seq_err;

  logic          w_acc, w_push, w_pop, w_dec, w_pv_out;
  logic [CW:0]   w_used;
  res_t          w_head, w_wr;

  // Credits count both in-flight ops and queued results so a push can never hit a full FIFO.
  assign w_used    = {1'b0, r_inflight} + {1'b0, r_count};
  assign req_ready = w_used < (CW+1)'(DEPTH);
  assign w_acc     = req_valid & req_ready;

  assign w_pv_out  = r_vld_pipe[LATENCY-1];
  assign w_push    = fpu_done & (r_count != CW'(DEPTH));
  assign w_pop     = wb_valid & wb_ready;
  assign w_dec     = fpu_done & (r_inflight != '0);

  assign w_wr.sum  = fpu_sum;
  assign w_wr.fex  = fpu_fex;
  assign w_wr.tag  = w_pv_out ? r_tag_pipe[LATENCY-1] : '0;

  assign w_head    = r_mem[r_rptr];
  assign wb_valid  = (r_count != '0);
  assign wb_sum    = w_head.sum;
  assign wb_fex    = w_head.fex;
  assign wb_tag    = w_head.tag;

  assign fpu_valid = r_fpu_valid;
  assign fpu_a     = r_fpu_a;
  assign fpu_b     = r_fpu_b;
  assign fflags    = r_fflags;
  assign seq_err   = r_seq_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fpu_valid <= 1'b0;
      r_fpu_a     <= '0;
      r_fpu_b     <= '0;
      r_tag       <= '0;
    end else begin
      r_fpu_valid <= w_acc;
      if (w_acc) begin
        r_fpu_a <= req_a;
        r_fpu_b <= req_b;
        r_tag   <= req_tag;
      end
    end
  end

  // Stage 0 samples the issue register, so the last stage lines up with the adder's done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_tag_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= r_fpu_valid;
      r_tag_pipe[0] <= r_tag;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_tag_pipe[i] <= r_tag_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      case ({w_acc, w_dec})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push) begin
        r_mem[r_wptr] <= w_wr;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fflags  <= '0;
      r_seq_err <= 1'b0;
    end else begin
      if (w_pop)           r_fflags <= (fflags_clr ? 3'b000 : r_fflags) | wb_fex;
      else if (fflags_clr) r_fflags <= '0;
      if (fpu_done != w_pv_out) r_seq_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpadd_issue_wb.sv
// Bench for fpadd_issue_wb: a stub adder with fixed latency, a scoreboard fed at accept
// time and a monitor that checks every issued operand pair and every retired result.
module tb_fpadd_issue_wb;
  localparam int DW = 32, TW = 5, LAT = 5, DEP = 8;

  logic          clk = 1'b0, rst = 1'b0;
  logic          req_valid = 1'b0, req_ready;
  logic [DW-1:0] req_a = '0, req_b = '0;
  logic [TW-1:0] req_tag = '0;
  logic          fpu_valid, fpu_done;
  logic [DW-1:0] fpu_a, fpu_b, fpu_sum;
  logic [2:0]    fpu_fex;
  logic          wb_valid, wb_ready = 1'b0;
  logic [DW-1:0] wb_sum;
  logic [2:0]    wb_fex, fflags;
  logic [TW-1:0] wb_tag;
  logic          fflags_clr = 1'b0, seq_err;

  fpadd_issue_wb #(.DWIDTH(DW), .TWIDTH(TW), .LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .fpu_valid(fpu_valid), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_sum(fpu_sum), .fpu_fex(fpu_fex), .fpu_done(fpu_done),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_sum(wb_sum), .wb_fex(wb_fex), .wb_tag(wb_tag),
    .fflags(fflags), .fflags_clr(fflags_clr), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  // Stub adder: known vectors return hand-computed IEEE results, anything else returns a^b.
  function automatic logic [34:0] stub(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return {32'h40400000, 3'b000};
    if (a == 32'h7F800000 && b == 32'hFF800000) return {32'h7FC00000, 3'b001};
    if (a == 32'h7F7FFFFF && b == 32'h7F7FFFFF) return {32'h7F800000, 3'b100};
    return {a ^ b, 3'b000};
  endfunction

  logic [LAT-1:0] ad_v;
  logic [DW-1:0]  ad_a [LAT];
  logic [DW-1:0]  ad_b [LAT];
  logic           inj_done = 1'b0;
  logic [34:0]    ad_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ad_v <= '0;
      for (int i = 0; i < LAT; i++) begin ad_a[i] <= '0; ad_b[i] <= '0; end
    end else begin
      ad_v    <= {ad_v[LAT-2:0], fpu_valid};
      ad_a[0] <= fpu_a;
      ad_b[0] <= fpu_b;
      for (int i = 1; i < LAT; i++) begin ad_a[i] <= ad_a[i-1]; ad_b[i] <= ad_b[i-1]; end
    end
  end

  assign ad_res   = stub(ad_a[LAT-1], ad_b[LAT-1]);
  assign fpu_sum  = ad_res[34:3];
  assign fpu_fex  = ad_res[2:0];
  assign fpu_done = ad_v[LAT-1] | inj_done;

  typedef struct packed { logic [31:0] sum; logic [2:0] fex; logic [4:0] tag; } exp_t;
  typedef struct packed { logic [31:0] a; logic [31:0] b; } iss_t;
  exp_t sb [$];
  iss_t isq [$];

  int vecs = 0, errs = 0, stalls = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: checks adder inputs and retiring results against the queues.
  exp_t me;
  iss_t mi;
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (fpu_valid) begin
        if (isq.size() == 0) chk("unexpected_issue", 1, 0);
        else begin
          mi = isq.pop_front();
          chk("fpu_a", fpu_a, mi.a);
          chk("fpu_b", fpu_b, mi.b);
        end
      end
      if (wb_valid && wb_ready) begin
        if (sb.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          me = sb.pop_front();
          chk("wb_sum", wb_sum, me.sum);
          chk("wb_fex", wb_fex, me.fex);
          chk("wb_tag", wb_tag, me.tag);
        end
      end
    end
  end

  task automatic expect_res(input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                            input logic [31:0] es, input logic [2:0] ef);
    exp_t e;
    iss_t s;
    e.sum = es; e.fex = ef; e.tag = tag;
    s.a = a; s.b = b;
    sb.push_back(e);
    isq.push_back(s);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                      input logic [31:0] es, input logic [2:0] ef);
    int n;
    n = 0;
    req_valid = 1'b1; req_a = a; req_b = b; req_tag = tag;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    stalls += n;
    if (n >= 200) chk("accept_timeout", 1, 0);
    else expect_res(a, b, tag, es, ef);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, acc, seen;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_fpu_valid", fpu_valid, 0);
    chk("rst_fpu_a", fpu_a, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_sum", {wb_sum, wb_fex, wb_tag}, 0);
    chk("rst_fflags", fflags, 0);
    chk("rst_seq_err", seq_err, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);

    // Single op: 1.0 + 2.0 = 3.0
    wb_ready = 1'b1;
    send(32'h3F800000, 32'h40000000, 5'd3, 32'h40400000, 3'b000);
    chk("single_fpu_valid_c1", fpu_valid, 1);
    n = 1;
    while (!wb_valid && n < 30) begin @(negedge clk); n++; end
    chk("single_wb_latency", n, 7);
    wait_drain();
    chk("single_fflags", fflags, 0);

    // Streaming, 20 back-to-back
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      logic [4:0] t;
      t = i[4:0];
      send(i << 8, 32'h1, t, (i << 8) | 32'h1, 3'b000);
    end
    chk("stream_no_stall", stalls, 0);
    wait_drain();
    chk("stream_seq_err", seq_err, 0);

    // Backpressure
    wb_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 12; k++) begin
      logic [4:0] t;
      t = k[4:0];
      req_valid = 1'b1; req_a = 32'hA000 + k; req_b = 32'h0; req_tag = t;
      if (req_ready) begin
        acc++;
        expect_res(32'hA000 + k, 32'h0, t, 32'hA000 + k, 3'b000);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("bp_accepts", acc, 8);
    repeat (10) @(negedge clk);
    chk("bp_req_ready_low", req_ready, 0);
    chk("bp_count_full", dut.r_count, 8);
    chk("bp_wb_valid", wb_valid, 1);
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    chk("bp_req_ready_after_pop", req_ready, 1);
    wb_ready = 1'b1;
    wait_drain();

    // Flags: inf + -inf = qNaN, invalid
    send(32'h7F800000, 32'hFF800000, 5'd9, 32'h7FC00000, 3'b001);
    wait_drain();
    chk("flags_invalid", fflags, 3'b001);
    wb_ready = 1'b0;
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 5'd10, 32'h7F800000, 3'b100);
    n = 0;
    while (!wb_valid && n < 30) begin @(negedge clk); n++; end
    wb_ready = 1'b1; fflags_clr = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0; fflags_clr = 1'b0;
    chk("flags_clr_with_pop", fflags, 3'b100);

    // Reset with 2 queued and 3 in flight
    send(32'h11, 32'h0, 5'd1, 32'h11, 3'b000);
    send(32'h22, 32'h0, 5'd2, 32'h22, 3'b000);
    repeat (8) @(negedge clk);
    send(32'h33, 32'h0, 5'd3, 32'h33, 3'b000);
    send(32'h44, 32'h0, 5'd4, 32'h44, 3'b000);
    send(32'h55, 32'h0, 5'd5, 32'h55, 3'b000);
    rst = 1'b1;
    sb.delete();
    isq.delete();
    #1;
    chk("midrst_fpu_valid", fpu_valid, 0);
    chk("midrst_wb_valid", wb_valid, 0);
    chk("midrst_wb_fields", {wb_sum, wb_fex, wb_tag}, 0);
    chk("midrst_fflags", fflags, 0);
    @(negedge clk);
    rst = 1'b0;
    wb_ready = 1'b1;
    seen = 0;
    repeat (15) begin @(negedge clk); if (wb_valid) seen++; end
    chk("midrst_no_wb_after", seen, 0);
    chk("midrst_req_ready", req_ready, 1);

    // Spurious done: pushed with tag 0, stub output 0^0
    inj_done = 1'b1;
    expect_res(32'h0, 32'h0, 5'd0, 32'h0, 3'b000);
    isq.pop_back();
    @(negedge clk);
    inj_done = 1'b0;
    chk("seq_err_set", seq_err, 1);
    repeat (5) @(negedge clk);
    chk("seq_err_sticky", seq_err, 1);
    wait_drain();
    chk("seq_err_sticky2", seq_err, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("seq_err_rst", seq_err, 0);

    chk("final_sb_empty", sb.size() + isq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/fpadd_issue_wb.md
# fpadd_issue_wb

Issue/writeback wrapper around the 32-bit pipelined floating-point adder.

- **Upstream side:** accepts add requests through a ready/valid handshake and drives the adder's `valid`/`a`/`b` inputs.
- **Tag tracking:** carries each request's destination tag through a latency-matched shift pipe.
- **Downstream side:** captures `sum`/`fex` on `done` into a result FIFO and presents tagged results to writeback.
- **Flow control:** the adder has no backpressure, so issue is credit-gated. A result is never dropped.
- **Flags:** architectural FP exception flags are accumulated on retirement.

## Interface

Parameters:
- `DWIDTH`, 32: operand/result width.
- `TWIDTH`, 5: destination tag width.
- `LATENCY`, 5: adder cycles from `valid` sampled to `done` asserted.
- `DEPTH`, 8: result FIFO entries (power of two, ≥2).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when high together with `req_valid`.
- `req_a`, `req_b` in `DWIDTH`: operands.
- `req_tag` in `TWIDTH`: destination tag.
- `fpu_valid` out 1: to adder `valid`.
- `fpu_a`, `fpu_b` out `DWIDTH`: to adder `a`/`b`.
- `fpu_sum` in `DWIDTH`: from adder `sum`.
- `fpu_fex` in 3: from adder `fex` (bit2 overflow, bit1 underflow, bit0 invalid/inexact).
- `fpu_done` in 1: from adder `done`.
- `wb_valid` out 1: FIFO head valid.
- `wb_ready` in 1: writeback consumes head.
- `wb_sum` out `DWIDTH`, `wb_fex` out 3, `wb_tag` out `TWIDTH`: FIFO head fields.
- `fflags` out 3: sticky accumulated exception flags.
- `fflags_clr` in 1: clear `fflags`.
- `seq_err` out 1: sticky protocol error (`done` without matching issue, or missing `done`).

## Operation

- **Accept:** `acc = req_valid & req_ready`.
- **Credits:**
  - `inflight` counts accepted requests whose `fpu_done` has not arrived.
  - `req_ready = (inflight + count) < DEPTH`, computed from registered values only (no same-cycle pop bypass).
  - `inflight` is +1 on `acc` and −1 on `fpu_done`; both in one cycle means no change.
- **Issue register:**
  - On `acc`: `fpu_a`/`fpu_b` <= `req_a`/`req_b`, `fpu_valid` <= 1.
  - Otherwise `fpu_valid` <= 0 and `fpu_a`/`fpu_b` hold.
  - Back-to-back issue every cycle is legal.
- **Tag pipe:**
  - `LATENCY`-stage shift register of {v, tag}.
  - Stage 0 loads {`fpu_valid`, tag registered with the issue}; it shifts every cycle.
  - The final stage aligns exactly with `fpu_done`.
- **Push:** on `fpu_done`, push {`fpu_sum`, `fpu_fex`, `pipe_tag_out`} into the FIFO. Credits guarantee that a push never meets a full FIFO.
- **Pop:**
  - The FIFO is show-ahead; `wb_*` reflect the head and `wb_valid = (count != 0)`.
  - Pop on `wb_valid & wb_ready`.
  - Simultaneous push and pop leaves `count` unchanged. With an empty FIFO, a push becomes visible the next cycle (no flow-through).
- **Pointers:** read/write pointers are log2(`DEPTH`) bits and wrap naturally.
- **fflags:**
  - On pop: `fflags` <= (`fflags_clr` ? 0 : `fflags`) | `wb_fex`.
  - Without pop: `fflags_clr` zeroes the register.
  - Set wins over clear in the same cycle.
- **seq_err:** set when `fpu_done != pipe_v_out`. It clears only on `rst`.
  - On `fpu_done` with `pipe_v_out = 0`, still push, with tag 0.
  - On `pipe_v_out` without `fpu_done`, no push and no `inflight` decrement.

## Timing

- **Reset values:** `req_ready` = 1 (after reset deassert), `fpu_valid` = 0, `fpu_a` = `fpu_b` = 0, `wb_valid` = 0, `wb_sum` = `wb_fex` = `wb_tag` = 0, `fflags` = 0, `seq_err` = 0. `inflight`, `count`, pointers and tag pipe are cleared.
- **Latency:** accept in cycle C gives `fpu_valid` in C+1, `fpu_done` in C+1+`LATENCY`, and `wb_valid` in C+2+`LATENCY` (default: C+7) when the FIFO is empty.
- **Throughput:** 1 request/cycle while credits remain.
- **Stall behaviour:** with `wb_ready` = 0 permanently, exactly `DEPTH` requests are accepted, then `req_ready` stays 0. One pop re-raises `req_ready` the cycle after the pop.
- **Ordering:** results retire in issue order.
- **Reset mid-operation:** all in-flight and queued results are discarded. The adder shares `rst`, so no stale `done` follows.

## Test plan

- **Single op:** `req_a` = 0x3F800000, `req_b` = 0x40000000, tag 3, accepted at cycle 0 -> `fpu_valid` in cycle 1; `wb_valid` in cycle 7 with `wb_sum` = 0x40400000, `wb_fex` = 0, `wb_tag` = 3; `fflags` stays 0 after pop.
- **Streaming:** 20 back-to-back requests, tags 0..19 mod 32, `wb_ready` = 1 -> `req_ready` never drops; results in order, one per cycle from cycle 7; `seq_err` = 0.
- **Backpressure:** `wb_ready` = 0, `req_valid` = 1 continuously -> exactly 8 accepts, `count` reaches 8 with no overflow. Raising `wb_ready` for 1 cycle -> one pop, then `req_ready` = 1 the next cycle.
- **Flags:** 0x7F800000 + 0xFF800000 -> `wb_sum` = 0x7FC00000, `wb_fex` = 001, `fflags` = 001 after pop. `fflags_clr` in the same cycle as a pop with `wb_fex` = 100 -> `fflags` = 100.
- **Reset mid-flight:** assert `rst` with 3 ops in flight and 2 queued -> all outputs at reset values; no `wb_valid` afterwards.
- **Protocol error:** inject a spurious `fpu_done` pulse with no issue -> `seq_err` = 1 and stays set until `rst`.
